div_radix2_axis: RTL and testbench

- In-house iterative radix-2 restoring divider.
- Acts as the responder end of the AXI-stream divider interface that the EX-stage divide unit drives: dividend/divisor slave channels in, quotient/remainder master channel out.
- Drop-in replacement for the vendor divider core, so EX-stage integer DIV/MOD/DIVU/MODU work without IP.
- One instance per signedness, selected by parameter.

---
 rtl/div_radix2_axis_if.sv | 34 +++
 rtl/div_radix2_axis.sv | 150 +++++++++++++++
 tb/tb_div_radix2_axis.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/div_radix2_axis_if.sv
// div_radix2_axis_if: AXI-stream bundle between the EX-stage divide unit and the divider.
//   s_axis_dividend_*  dividend channel (tdata WIDTH bits, tvalid, tready)
//   s_axis_divisor_*   divisor channel  (tdata WIDTH bits, tvalid, tready)
//   m_axis_dout_*      result channel   (tdata {quotient, remainder}, tvalid, tready)
// The master modport is the requester side (divide unit); the slave modport is the divider.
interface div_radix2_axis_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0]   s_axis_dividend_tdata;
  logic               s_axis_dividend_tvalid;
  logic               s_axis_dividend_tready;
  logic [WIDTH-1:0]   s_axis_divisor_tdata;
  logic               s_axis_divisor_tvalid;
  logic               s_axis_divisor_tready;
  logic [2*WIDTH-1:0] m_axis_dout_tdata;
  logic               m_axis_dout_tvalid;
  logic               m_axis_dout_tready;

  modport master (
    output s_axis_dividend_tdata, s_axis_dividend_tvalid,
    output s_axis_divisor_tdata, s_axis_divisor_tvalid,
    output m_axis_dout_tready,
    input  s_axis_dividend_tready, s_axis_divisor_tready,
    input  m_axis_dout_tdata, m_axis_dout_tvalid
  );

  modport slave (
    input  s_axis_dividend_tdata, s_axis_dividend_tvalid,
    input  s_axis_divisor_tdata, s_axis_divisor_tvalid,
    input  m_axis_dout_tready,
    output s_axis_dividend_tready, s_axis_divisor_tready,
    output m_axis_dout_tdata, m_axis_dout_tvalid
  );
endinterface

// File: rtl/div_radix2_axis.sv
// div_radix2_axis: iterative radix-2 restoring divider with AXI-stream operand/result channels.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   axis   div_radix2_axis_if.slave: dividend/divisor in, {quotient, remainder} out
// Parameters: WIDTH operand width, SIGNED 1 = two's-complement, 0 = unsigned.
// Optional macro DIV_OUT_TREADY_EN: when defined, the result is held until m_axis_dout_tready;
// when undefined, m_axis_dout_tvalid is a single-cycle pulse and tready is ignored.
// One operation in flight; result appears WIDTH+1 cycles after the accept edge.
module div_radix2_axis #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          SIGNED = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  div_radix2_axis_if.slave axis
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_abs_q, dvs_abs_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               div0_q, div0_d;
  logic [2*WIDTH-1:0] dout_q, dout_d;
  logic               valid_q, valid_d;

  logic               accept;
  logic               dvd_neg, dvs_neg;
  logic [WIDTH-1:0]   dvd_abs, dvs_abs;
  logic [WIDTH:0]     shifted, trial;
  logic [WIDTH-1:0]   q_fin, r_fin;

  // Both channels transfer together; a lone tvalid is left waiting.
  assign accept = (state_q == IDLE) & axis.s_axis_dividend_tvalid & axis.s_axis_divisor_tvalid;
  assign axis.s_axis_dividend_tready = accept;
  assign axis.s_axis_divisor_tready  = accept;
  assign axis.m_axis_dout_tdata      = dout_q;
  assign axis.m_axis_dout_tvalid     = valid_q;

`ifndef DIV_OUT_TREADY_EN
  logic unused_dout_tready;
  assign unused_dout_tready = axis.m_axis_dout_tready;
`endif

  assign dvd_neg = SIGNED & axis.s_axis_dividend_tdata[WIDTH-1];
  assign dvs_neg = SIGNED & axis.s_axis_divisor_tdata[WIDTH-1];
  // -MIN wraps to MIN, which read as unsigned is exactly 2^(WIDTH-1).
  assign dvd_abs = dvd_neg ? -axis.s_axis_dividend_tdata : axis.s_axis_dividend_tdata;
  assign dvs_abs = dvs_neg ? -axis.s_axis_divisor_tdata : axis.s_axis_divisor_tdata;

  // Partial remainder stays below |divisor|, so only the shifted/trial value needs WIDTH+1 bits.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_abs_q};

  // Divide by zero bypasses sign correction: all-ones quotient, raw dividend as remainder.
  assign q_fin = div0_q ? '1 : (qneg_q ? -quo_q : quo_q);
  assign r_fin = div0_q ? dvd_q : (rneg_q ? -rem_q : rem_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_abs_d = dvs_abs_q;
    dvd_d     = dvd_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    div0_d    = div0_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          dvd_d     = axis.s_axis_dividend_tdata;
          dvs_abs_d = dvs_abs;
          quo_d     = dvd_abs;
          rem_d     = '0;
          cnt_d     = '0;
          qneg_d    = dvd_neg ^ dvs_neg;
          rneg_d    = dvd_neg;
          div0_d    = (axis.s_axis_divisor_tdata == '0);
          state_d   = CALC;
        end
      end
      CALC: begin
        if (cnt_q == CntW'(WIDTH)) begin
          // All quotient bits done; this cycle registers the corrected result.
          dout_d  = {q_fin, r_fin};
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DONE: begin
`ifdef DIV_OUT_TREADY_EN
        if (axis.m_axis_dout_tready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
`else
        valid_d = 1'b0;
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_abs_q <= '0;
      dvd_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      div0_q    <= 1'b0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_abs_q <= dvs_abs_d;
      dvd_q     <= dvd_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      div0_q    <= div0_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_div_radix2_axis.sv
// tb_div_radix2_axis: drives an unsigned and a signed divider with identical stimulus and
// checks both against an arithmetic reference model.
module tb_div_radix2_axis;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] dvd = '0;
  logic [W-1:0] dvs = '0;
  logic         dvd_v = 1'b0;
  logic         dvs_v = 1'b0;
  logic         out_rdy = 1'b0;

  always #5 clk = ~clk;

  div_radix2_axis_if #(.WIDTH(W)) if_u ();
  div_radix2_axis_if #(.WIDTH(W)) if_s ();

  assign if_u.s_axis_dividend_tdata  = dvd;
  assign if_u.s_axis_dividend_tvalid = dvd_v;
  assign if_u.s_axis_divisor_tdata   = dvs;
  assign if_u.s_axis_divisor_tvalid  = dvs_v;
  assign if_u.m_axis_dout_tready     = out_rdy;
  assign if_s.s_axis_dividend_tdata  = dvd;
  assign if_s.s_axis_dividend_tvalid = dvd_v;
  assign if_s.s_axis_divisor_tdata   = dvs;
  assign if_s.s_axis_divisor_tvalid  = dvs_v;
  assign if_s.m_axis_dout_tready     = out_rdy;

  div_radix2_axis #(.WIDTH(W), .SIGNED(1'b0)) u_dut_u (.clk(clk), .rst_n(rst_n), .axis(if_u));
  div_radix2_axis #(.WIDTH(W), .SIGNED(1'b1)) u_dut_s (.clk(clk), .rst_n(rst_n), .axis(if_s));

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic; SV signed / and % truncate toward zero.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  function automatic logic [63:0] treadys();
    return 64'({if_u.s_axis_dividend_tready, if_u.s_axis_divisor_tready,
                if_s.s_axis_dividend_tready, if_s.s_axis_divisor_tready});
  endfunction

  function automatic logic [63:0] valids();
    return 64'({if_u.m_axis_dout_tvalid, if_s.m_axis_dout_tvalid});
  endfunction

  // One full operation on both DUTs, with latency, result and exit checks.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int stall,
                       input string tag);
    logic [63:0] eu, es;
    eu = ref_div(1'b0, a, b);
    es = ref_div(1'b1, a, b);
    @(negedge clk);
    dvd = a; dvs = b; dvd_v = 1'b1; dvs_v = 1'b1;
    #1 check({tag, " accept tready"}, treadys(), 64'hF);
    @(posedge clk);
    #1 dvd_v = 1'b0; dvs_v = 1'b0;
    repeat (W) @(posedge clk);
    #1 check({tag, " tvalid early"}, valids(), 64'h0);
    @(posedge clk);
    #1 check({tag, " tvalid at latency"}, valids(), 64'h3);
    check({tag, " unsigned result"}, if_u.m_axis_dout_tdata, eu);
    check({tag, " signed result"}, if_s.m_axis_dout_tdata, es);
`ifdef DIV_OUT_TREADY_EN
    if (stall > 0) begin
      @(negedge clk);
      dvd_v = 1'b1; dvs_v = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk);
        #1 check({tag, " stall tvalid"}, valids(), 64'h3);
        check({tag, " stall data u"}, if_u.m_axis_dout_tdata, eu);
        check({tag, " stall data s"}, if_s.m_axis_dout_tdata, es);
        check({tag, " stall tready"}, treadys(), 64'h0);
      end
    end
    @(negedge clk);
    dvd_v = 1'b0; dvs_v = 1'b0; out_rdy = 1'b1;
    @(posedge clk);
    #1 check({tag, " tvalid clears"}, valids(), 64'h0);
    out_rdy = 1'b0;
`else
    // tready is ignored without the macro; leaving it low must not hold the result.
    @(posedge clk);
    #1 check({tag, " tvalid pulse ends"}, valids(), 64'h0);
    check({tag, " data held"}, {if_u.m_axis_dout_tdata[63:32], if_s.m_axis_dout_tdata[63:32]},
          {eu[63:32], es[63:32]});
    if (stall > 0) check({tag, " data held rem"}, if_s.m_axis_dout_tdata, es);
`endif
  endtask

  task automatic watch_quiet(input int cycles, input string tag);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1 seen = seen | (|valids());
    end
    check(tag, 64'(seen), 64'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra, rb;

    // Reset state.
    #1 check("reset tvalid", valids(), 64'h0);
    check("reset data u", if_u.m_axis_dout_tdata, 64'h0);
    check("reset data s", if_s.m_axis_dout_tdata, 64'h0);
    check("reset tready", treadys(), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases, with literal cross-checks of the model.
    do_op(32'd100, 32'd7, 0, "100/7");
    check("100/7 literal", if_u.m_axis_dout_tdata, 64'h0000000E_00000002);
    do_op(32'hFFFF_FFF9, 32'd2, 4, "-7/2");
    check("-7/2 literal", if_s.m_axis_dout_tdata, 64'hFFFFFFFD_FFFFFFFF);
    do_op(32'd7, 32'hFFFF_FFFE, 0, "7/-2");
    check("7/-2 literal", if_s.m_axis_dout_tdata, 64'hFFFFFFFD_00000001);
    do_op(32'h1234_5678, 32'd0, 0, "div0");
    check("div0 literal u", if_u.m_axis_dout_tdata, 64'hFFFFFFFF_12345678);
    check("div0 literal s", if_s.m_axis_dout_tdata, 64'hFFFFFFFF_12345678);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 0, "min/-1");
    check("min/-1 literal", if_s.m_axis_dout_tdata, 64'h80000000_00000000);
    do_op(32'hF000_0000, 32'd0, 0, "neg div0");
    do_op(32'd0, 32'd5, 0, "0/5");
    do_op(32'd5, 32'hFFFF_FFFF, 0, "5/-1");
    do_op(32'h7FFF_FFFF, 32'd1, 0, "max/1");
    do_op(32'h8000_0000, 32'h8000_0000, 0, "min/min");

    // Lone dividend tvalid must never be consumed.
    @(negedge clk);
    dvd = 32'd55; dvs = 32'd5; dvd_v = 1'b1; dvs_v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 check("lone tvalid tready", treadys(), 64'h0);
    end
    @(negedge clk);
    dvd_v = 1'b0;
    watch_quiet(W + 4, "lone tvalid no result");

    // Reset during CALC aborts the operation.
    @(negedge clk);
    dvd = 32'h1234_5678; dvs = 32'd7; dvd_v = 1'b1; dvs_v = 1'b1;
    @(posedge clk);
    #1 dvd_v = 1'b0; dvs_v = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("midcalc reset tvalid", valids(), 64'h0);
    check("midcalc reset data u", if_u.m_axis_dout_tdata, 64'h0);
    check("midcalc reset data s", if_s.m_axis_dout_tdata, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_quiet(W + 8, "aborted op silent");
    do_op(32'd9, 32'd3, 0, "9/3");
    check("9/3 literal u", if_u.m_axis_dout_tdata, 64'h00000003_00000000);
    check("9/3 literal s", if_s.m_axis_dout_tdata, 64'h00000003_00000000);

    // Randomized operands, back to back.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(1, 15));
        1: rb = -32'($urandom_range(1, 15));
        2: rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      do_op(ra, rb, int'($urandom_range(0, 2)), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
